// File: rtl/xor_parity_rx.sv
// Serial frame receiver: DATA_W data bits LSB first followed by one parity bit.
// Reports the assembled word with a parity check and flags frames restarted mid-way.
module xor_parity_rx #(
    parameter int unsigned DATA_W     = 8,
    parameter bit          ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic              in_start,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              parity_err,
    output logic              frame_abort,
    output logic              busy
);

    localparam int unsigned CntW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              xor_q, xor_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_abort_q, frame_abort_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // A start beat always begins a fresh frame, whatever state we are in.
    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            if (in_start) begin
                state_d = StData;
            end else begin
                unique case (state_q)
                    StIdle:   state_d = StIdle;
                    StData:   if (cnt_q == CntW'(DATA_W - 1)) state_d = StParity;
                    StParity: state_d = StIdle;
                    default:  state_d = StIdle;
                endcase
            end
        end
    end

    always_comb begin
        cnt_d         = cnt_q;
        xor_d         = xor_q;
        data_d        = data_q;
        out_valid_d   = 1'b0;
        out_data_d    = out_data_q;
        parity_err_d  = parity_err_q;
        frame_abort_d = 1'b0;
        if (in_valid) begin
            if (in_start) begin
                frame_abort_d = (state_q != StIdle);
                data_d        = '0;
                data_d[0]     = in_bit;
                xor_d         = in_bit;
                cnt_d         = CntW'(1);
            end else if (state_q == StData) begin
                for (int i = 0; i < int'(DATA_W); i++) begin
                    if (cnt_q == CntW'(i)) data_d[i] = in_bit;
                end
                xor_d = xor_q ^ in_bit;
                cnt_d = cnt_q + CntW'(1);
            end else if (state_q == StParity) begin
                out_valid_d  = 1'b1;
                out_data_d   = data_q;
                parity_err_d = xor_q ^ in_bit ^ ODD_PARITY;
                cnt_d        = '0;
                xor_d        = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            xor_q         <= 1'b0;
            data_q        <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            parity_err_q  <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            xor_q         <= xor_d;
            data_q        <= data_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            parity_err_q  <= parity_err_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    always_comb begin
        busy        = (state_q != StIdle);
        out_valid   = out_valid_q;
        out_data    = out_data_q;
        parity_err  = parity_err_q;
        frame_abort = frame_abort_q;
    end

endmodule

// File: doc/xor_parity_rx.md
XOR_PARITY_RX -- requirements
Module: xor_parity_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, number of data bits per frame (legal range 2..32).
REQ-002 SHALL have parameter ODD_PARITY, default 0; 0 selects even parity, 1 selects odd parity.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  in_bit/in_start are sampled only when high.
REQ-006 SHALL have port in_bit  input  1  serial bit, data LSB first, then the parity bit.
REQ-007 SHALL have port in_start  input  1  marks the accepted bit as data bit 0 of a new frame.
REQ-008 SHALL have port out_valid  output  1  one-cycle pulse, frame complete.
REQ-009 SHALL have port out_data  output  DATA_W  received data word, valid with out_valid.
REQ-010 SHALL have port parity_err  output  1  parity mismatch flag, valid with out_valid.
REQ-011 SHALL have port frame_abort  output  1  one-cycle pulse, frame restarted before completion.
REQ-012 SHALL have port busy  output  1  high while in DATA or PARITY state.

Function
REQ-013 SHALL implement FSM states IDLE, DATA, PARITY; busy = (state != IDLE), combinational from state.
REQ-014 SHALL treat a cycle with in_valid=1 as a beat; cycles with in_valid=0 SHALL leave all internal state unchanged (gaps allowed anywhere).
REQ-015 IDLE: a beat with in_start=1 SHALL store in_bit as data bit 0, load running XOR with in_bit, set bit count to 1, go to DATA; a beat with in_start=0 SHALL be ignored.
REQ-016 DATA: each beat with in_start=0 SHALL store in_bit at bit position = count, XOR it into the running parity, and increment count; the beat storing bit DATA_W-1 SHALL go to PARITY.
REQ-017 PARITY: a beat with in_start=0 SHALL be taken as the parity bit and SHALL go to IDLE.
REQ-018 On the cycle after the parity beat, out_valid SHALL be 1 for exactly one cycle, with out_data = assembled word and parity_err = running_xor ^ parity_bit ^ ODD_PARITY.
REQ-019 out_data and parity_err SHALL hold their values until the next completed frame; out_valid SHALL be 0 at all other times.
REQ-020 A beat with in_start=1 in DATA or PARITY SHALL discard the partial frame, pulse frame_abort for one cycle on the next cycle, and restart per REQ-015 using that beat as new bit 0.
REQ-021 A start beat in the same cycle that out_valid is high SHALL be accepted normally, allowing back-to-back frames with no idle cycle.
REQ-022 Maximum throughput SHALL be one frame per DATA_W+1 beats.
REQ-023 Bit count SHALL be ceil(log2(DATA_W+1)) bits wide and SHALL never exceed DATA_W.

Reset
REQ-024 When rst_n=0 at a clock edge: state=IDLE, count=0, running XOR=0, out_valid=0, out_data=0, parity_err=0, frame_abort=0.
REQ-025 Reset SHALL take priority over any beat in the same cycle; a partial frame SHALL be discarded without out_valid or frame_abort.

Verification
REQ-026 DATA_W=8, even: start beat with bit 1, then bits 0,1,0,0,1,0,1 (0xA5), parity 0 -> next cycle out_valid=1, out_data=0xA5, parity_err=0.
REQ-027 Same frame with parity bit 1 -> out_data=0xA5, parity_err=1; frame 0x00 with parity 0 -> parity_err=0.
REQ-028 ODD_PARITY=1: 0x01 with parity 0 -> parity_err=0; 0x01 with parity 1 -> parity_err=1.
REQ-029 0x3C sent with random in_valid gaps (0-3 idle cycles between beats) -> out_data=0x3C, parity_err=0, exactly one out_valid pulse.
REQ-030 Start frame, send 4 bits, then start beat of 0x81 frame -> frame_abort pulse one cycle, then out_data=0x81 with correct parity.
REQ-031 rst_n=0 for one cycle after 5 bits of a frame -> busy=0, no out_valid or frame_abort; next full frame 0x5A decodes correctly.
